// File: rtl/mac_arb_pkg.sv
// mac_arb_pkg
//   Shared types and default sizes for the MAC job arbiter.
//   state_e : job FSM states (IDLE, GRANT, CLEAR, STREAM, DRAIN, DONE)
//   DEFAULT_* : default operand/accumulator/length widths and MAC latency
package mac_arb_pkg;

  localparam int unsigned DEFAULT_DATA_W  = 8;
  localparam int unsigned DEFAULT_ACC_W   = 16;
  localparam int unsigned DEFAULT_LEN_W   = 4;
  localparam int unsigned DEFAULT_MAC_LAT = 3;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: first set req bit at or after rr_ptr,
//   wrapping around.
//   req    : request vector
//   rr_ptr : search start position
//   owner  : index of the picked requester (0 when none)
//   found  : a request was picked
module rr_arbiter
  import mac_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    found
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic [IDW-1:0] cand;

  always_comb begin
    owner = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        owner = cand;
      end
    end
  end

endmodule

// File: rtl/mac_job_arbiter.sv
// mac_job_arbiter
//   Shares one signed multiply-accumulate pipeline between NREQ requesters.
//   Jobs are picked round-robin; each job clears the accumulator, streams
//   its operand pairs into the MAC, waits for all results and returns the
//   final sum with a sticky overflow flag and the owner ID.
//
//   Optional feature: define MAC_ARB_TIMEOUT_EN to add a stall watchdog
//   (TIMEOUT cycles without handshake or MAC result aborts the job) and
//   the res_timeout output.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   req / req_len / gnt   : job request, job length, one-cycle grant
//   op_a/op_b/op_valid    : per-requester operand pair stream
//   op_ready              : operand pair accepted (owner's bit only)
//   mac_clear             : MAC synchronous clear (held during reset)
//   mac_a/mac_b/mac_valid_in : operand pair to the MAC
//   mac_f/mac_overflow/mac_valid_out : MAC result
//   res_f/res_ovf/res_id/res_valid   : job result, one-cycle pulse
//   res_timeout           : job aborted by watchdog (MAC_ARB_TIMEOUT_EN only)
//   busy                  : FSM not in IDLE
module mac_job_arbiter
  import mac_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned ACC_W   = DEFAULT_ACC_W,
  parameter int unsigned LEN_W   = DEFAULT_LEN_W,
  parameter int unsigned MAC_LAT = DEFAULT_MAC_LAT,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  output logic [NREQ-1:0]         gnt,
  input  logic [NREQ*DATA_W-1:0]  op_a,
  input  logic [NREQ*DATA_W-1:0]  op_b,
  input  logic [NREQ-1:0]         op_valid,
  output logic [NREQ-1:0]         op_ready,
  output logic                    mac_clear,
  output logic [DATA_W-1:0]       mac_a,
  output logic [DATA_W-1:0]       mac_b,
  output logic                    mac_valid_in,
  input  logic [ACC_W-1:0]        mac_f,
  input  logic                    mac_overflow,
  input  logic                    mac_valid_out,
  output logic [ACC_W-1:0]        res_f,
  output logic                    res_ovf,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic                    res_valid,
`ifdef MAC_ARB_TIMEOUT_EN
  output logic                    res_timeout,
`endif
  output logic                    busy
);

  localparam int unsigned IDW = $clog2(NREQ);

  state_e          state;
  logic [IDW-1:0]  owner_q;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  ptr_nx;
  logic            found;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0]  len_ext;
  logic [LEN_W:0]  issued;
  logic [LEN_W:0]  issued_nx;
  logic [LEN_W:0]  returned;
  logic [LEN_W:0]  returned_nx;
  logic            ovf_sticky;
  logic            hs;

  logic [DATA_W-1:0] a_arr   [NREQ];
  logic [DATA_W-1:0] b_arr   [NREQ];
  logic [LEN_W-1:0]  len_arr [NREQ];

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr (
    .req   (req),
    .rr_ptr(rr_ptr),
    .owner (pick),
    .found (found)
  );

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      a_arr[i]   = op_a[i*DATA_W +: DATA_W];
      b_arr[i]   = op_b[i*DATA_W +: DATA_W];
      len_arr[i] = req_len[i*LEN_W +: LEN_W];
    end
  end

  always_comb begin
    len_ext     = {1'b0, len_q};
    hs          = (state == STREAM) && op_valid[owner_q] && op_ready[owner_q];
    issued_nx   = issued + {{LEN_W{1'b0}}, hs};
    returned_nx = returned + {{LEN_W{1'b0}}, mac_valid_out};
    ptr_nx      = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  end

`ifdef MAC_ARB_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_nx;
  logic               stall_hit;

  always_comb begin
    stall_nx  = (hs || mac_valid_out) ? '0 : stall_cnt + 1'b1;
    stall_hit = ((state == STREAM) || (state == DRAIN)) && (stall_nx == STALL_W'(TIMEOUT));
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner_q      <= '0;
      rr_ptr       <= '0;
      len_q        <= '0;
      issued       <= '0;
      returned     <= '0;
      ovf_sticky   <= 1'b0;
      gnt          <= '0;
      op_ready     <= '0;
      mac_clear    <= 1'b1;
      mac_a        <= '0;
      mac_b        <= '0;
      mac_valid_in <= 1'b0;
      res_f        <= '0;
      res_ovf      <= 1'b0;
      res_id       <= '0;
      res_valid    <= 1'b0;
      busy         <= 1'b0;
`ifdef MAC_ARB_TIMEOUT_EN
      stall_cnt    <= '0;
      res_timeout  <= 1'b0;
`endif
    end else begin
      gnt          <= '0;
      op_ready     <= '0;
      mac_clear    <= 1'b0;
      mac_a        <= '0;
      mac_b        <= '0;
      mac_valid_in <= 1'b0;
      res_valid    <= 1'b0;
`ifdef MAC_ARB_TIMEOUT_EN
      res_timeout  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            owner_q    <= pick;
            len_q      <= len_arr[pick];
            gnt[pick]  <= 1'b1;
            busy       <= 1'b1;
            state      <= GRANT;
          end
        end
        GRANT: begin
          rr_ptr    <= ptr_nx;
          mac_clear <= 1'b1;
          state     <= CLEAR;
        end
        CLEAR: begin
          issued     <= '0;
          returned   <= '0;
          ovf_sticky <= 1'b0;
`ifdef MAC_ARB_TIMEOUT_EN
          stall_cnt  <= '0;
`endif
          if (len_q == '0) begin
            res_f     <= '0;
            res_ovf   <= 1'b0;
            res_id    <= owner_q;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            op_ready[owner_q] <= 1'b1;
            state             <= STREAM;
          end
        end
        STREAM: begin
          ovf_sticky <= ovf_sticky | mac_overflow;
          returned   <= returned_nx;
          issued     <= issued_nx;
          if (hs) begin
            mac_a        <= a_arr[owner_q];
            mac_b        <= b_arr[owner_q];
            mac_valid_in <= 1'b1;
          end
          // op_ready is registered, so it is computed from the post-handshake count
          if (issued_nx == len_ext) begin
            state <= DRAIN;
          end else begin
            op_ready[owner_q] <= 1'b1;
          end
        end
        DRAIN: begin
          ovf_sticky <= ovf_sticky | mac_overflow;
          returned   <= returned_nx;
          if (mac_valid_out && (returned_nx == len_ext)) begin
            res_f     <= mac_f;
            res_ovf   <= ovf_sticky | mac_overflow;
            res_id    <= owner_q;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
`ifdef MAC_ARB_TIMEOUT_EN
      if ((state == STREAM) || (state == DRAIN)) begin
        stall_cnt <= stall_nx;
      end
      // Watchdog overrides whatever STREAM/DRAIN decided this cycle
      if (stall_hit) begin
        op_ready    <= '0;
        res_f       <= '0;
        res_ovf     <= 1'b1;
        res_id      <= owner_q;
        res_valid   <= 1'b1;
        res_timeout <= 1'b1;
        state       <= DONE;
      end
`endif
    end
  end

  // A stall limit not exceeding the MAC latency would abort every job
  a_cfg_ok: assert property (@(posedge clk)
    (NREQ >= 2) && (NREQ <= 8) && (MAC_LAT >= 1) && (TIMEOUT > MAC_LAT));

endmodule

// File: doc/mac_job_arbiter.md
Name: mac_job_arbiter

Overview:
- Shares one signed 8x8->16 multiply-accumulate pipeline between NREQ requesters.
- Each requester submits a dot-product job: a length, then a stream of operand pairs.
- Picks the next job by round-robin, clears the accumulator, and streams the operand pairs into the MAC.
- Counts MAC valid outputs, then returns the final sum, a sticky overflow flag and the requester ID.
- Sits between client engines and the shared MAC datapath.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DATA_W, 8, operand width
- ACC_W, 16, accumulator/result width
- LEN_W, 4, job-length field width; maximum job length is 2^LEN_W-1
- MAC_LAT, 3, cycles from mac_valid_in to the matching mac_valid_out
- TIMEOUT, 64, stall limit in cycles (used only by the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  NREQ  per-requester job request, held until gnt
- req_len  in  NREQ*LEN_W  per-requester job length, sampled at grant
- gnt  out  NREQ  one-hot, one-cycle pulse accepting a job
- op_a  in  NREQ*DATA_W  signed operand A per requester
- op_b  in  NREQ*DATA_W  signed operand B per requester
- op_valid  in  NREQ  operand pair valid
- op_ready  out  NREQ  operand pair accepted; only the owner's bit can be high
- mac_clear  out  1  drives the MAC synchronous reset
- mac_a  out  DATA_W  operand A to the MAC
- mac_b  out  DATA_W  operand B to the MAC
- mac_valid_in  out  1  operand pair valid to the MAC
- mac_f  in  ACC_W  MAC accumulator output
- mac_overflow  in  1  MAC overflow output
- mac_valid_out  in  1  MAC result valid
- res_f  out  ACC_W  final job sum
- res_ovf  out  1  overflow occurred anywhere in the job
- res_id  out  $clog2(NREQ)  owner of the result
- res_valid  out  1  one-cycle result pulse
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: gnt=0, op_ready=0, mac_clear=1 (held during reset), mac_a=0, mac_b=0, mac_valid_in=0, res_f=0, res_ovf=0, res_id=0, res_valid=0, busy=0, rr_ptr=0, state=IDLE.
- Reset mid-job abandons the job; no res_valid is issued for it.
- FSM states: IDLE, GRANT, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - If any req bit is high, pick the first set bit at or after rr_ptr, wrapping around.
  - Go to GRANT, latch owner and len=req_len[owner].
- GRANT:
  - Pulse gnt[owner] for exactly 1 cycle.
  - Set rr_ptr = owner+1 mod NREQ.
  - Go to CLEAR.
- CLEAR:
  - Assert mac_clear for 1 cycle.
  - Zero the issue counter, the return counter and the sticky overflow register.
  - If len==0, go to DONE with res_f=0 and res_ovf=0.
  - Otherwise go to STREAM.
- STREAM:
  - op_ready[owner]=1 while issued<len.
  - On op_valid&&op_ready, register mac_a/mac_b from the owner's operands and set mac_valid_in=1 the next cycle; otherwise mac_valid_in=0 and mac_a=mac_b=0.
  - Go to DRAIN when issued==len.
  - Bubbles (op_valid low) are legal and are not counted.
- Every cycle from STREAM through DRAIN: ovf_sticky |= mac_overflow.
- Each mac_valid_out increments returned.
- DRAIN: on the mac_valid_out that makes returned==len, capture res_f=mac_f and res_ovf=ovf_sticky|mac_overflow, then go to DONE.
- DONE:
  - res_valid=1 for 1 cycle with res_id=owner.
  - Go to IDLE.
  - res_f, res_ovf and res_id hold until the next DONE.
- Minimum turnaround for a len=L job without bubbles: 1 (IDLE) + 1 (GRANT) + 1 (CLEAR) + L + MAC_LAT + 1 cycles.
- If a requester raises req while its own job is running, that request is served only after a full round-robin pass.
- Requests arriving in the same cycle as DONE are considered in the next IDLE cycle.
- A mac_valid_out seen outside STREAM/DRAIN is ignored.
- Counters are LEN_W+1 bits wide and never wrap within a job.

Optional Feature:
- Macro: MAC_ARB_TIMEOUT_EN.
- Defined:
  - A stall counter runs in STREAM and DRAIN and resets on any handshake or mac_valid_out.
  - When it reaches TIMEOUT, the job aborts: res_f=0 and res_ovf=1, and DONE issues res_valid with the owner ID.
  - An extra output res_timeout (1 bit) is high with that pulse.
- Undefined:
  - No counter and no res_timeout port.
  - A job waits indefinitely for operands.

Decomposition:
- Package mac_arb_pkg:
  - state_e enum (IDLE, GRANT, CLEAR, STREAM, DRAIN, DONE).
  - Default width constants DATA_W=8, ACC_W=16, LEN_W=4.
  - Constant MAC_LAT=3.
- Sub-module rr_arbiter: combinational round-robin pick from req and rr_ptr, producing owner and a found flag.
- The FSM, counters and operand mux stay in mac_job_arbiter.

Test Plan:
- Single job, req[0], len=3, pairs (2,2),(3,3),(4,4), no bubbles -> gnt[0] pulses once; res_f=29, res_ovf=0, res_id=0; res_valid 10 cycles after req seen in IDLE.
- req[0..3] all held, each len=1 with (1,1) -> gnt order 0,1,2,3, then 0 again; each res_f=1.
- Bubbles: len=2, op_valid low 3 cycles between pairs (5,-3),(-2,-2) -> exactly 2 mac_valid_in pulses; res_f=-11.
- Overflow: len=3 with (127,127),(127,127),(127,127) -> res_ovf=1; a following job (1,1) -> res_ovf=0, res_f=1.
- len=0 on req[2] -> gnt[2], mac_valid_in never asserted, res_f=0, res_valid one cycle after CLEAR.
- Reset asserted mid-STREAM -> all outputs reach reset values next cycle, no res_valid; the next job is granted from rr_ptr=0.
